// File: rtl/fixed_mul_pipe.sv
// fixed_mul_pipe -- pipelined signed fixed-point multiplier (radix-4 Booth).
//
// One Booth partial product is accumulated per stage (STEPS = ceil(WIDTH/2)
// stages). A final output register adds the Q-format rescale. The total
// latency is STEPS+1 cycles. The pipeline accepts one operation per cycle and
// stalls as a whole while a result is held (dout_valid & ~dout_ready).
//
// Parameters: WIDTH (operand bits), FRAC (fractional bits), TAG_W (tag bits)
// Ports:
//   clk, nrst                 clock, async active-low reset
//   din1, din2, din_tag       signed operands + sideband tag
//   din_valid / din_ready     input handshake
//   flush                     drop every in-flight operation (sync)
//   dout                      full 2*WIDTH signed product
//   dout_fx, dout_ovf         product rescaled to input Q format, overflow flag
//   dout_tag                  tag of the result on dout
//   dout_valid / dout_ready   output handshake
// Build option: define FIXED_MUL_PIPE_SAT_EN to saturate dout_fx on overflow
// (otherwise dout_fx wraps and dout_ovf is 0).

// One Booth accumulation stage: registers valid/tag/operands and
// acc_prev + digit(m) * a_prev * 4^J.
module fixed_mul_pipe_stage #(
  parameter int WIDTH = 26,
  parameter int TAG_W = 4,
  parameter int MW    = 26,
  parameter int J     = 0
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 adv,
  input  logic                 flush,
  input  logic                 vld_prev,
  input  logic [TAG_W-1:0]     tag_prev,
  input  logic [WIDTH-1:0]     a_prev,
  input  logic [MW:0]          m_prev,
  input  logic [2*WIDTH-1:0]   acc_prev,
  output logic                 vld,
  output logic [TAG_W-1:0]     tag,
  output logic [WIDTH-1:0]     a,
  output logic [MW:0]          m,
  output logic [2*WIDTH-1:0]   acc
);
  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] pp;
  logic        [PW-1:0] acc_nxt;

  assign a_ext = PW'($signed(a_prev));

  // m_prev[2:0] = {b(2j+1), b(2j), b(2j-1)} of the multiplier.
  always_comb begin
    pp = '0;
    case (m_prev[2:0])
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_ext <<< 1;
      3'b100:         pp = -(a_ext <<< 1);
      3'b101, 3'b110: pp = -a_ext;
      default:        pp = '0;
    endcase
  end

  // Modulo-2^PW accumulation is exact: the true product always fits PW bits.
  assign acc_nxt = acc_prev + (pp << (2 * J));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)      vld <= 1'b0;
    else if (flush) vld <= 1'b0;
    else if (adv)   vld <= vld_prev;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      tag <= tag_prev;
      a   <= a_prev;
      m   <= {2'b00, m_prev[MW:2]};   // next stage sees the next Booth triplet
      acc <= acc_nxt;
    end
  end
endmodule

module fixed_mul_pipe #(
  parameter int WIDTH = 26,
  parameter int FRAC  = 13,
  parameter int TAG_W = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic signed [WIDTH-1:0]   din1,
  input  logic signed [WIDTH-1:0]   din2,
  input  logic [TAG_W-1:0]          din_tag,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic                      flush,
  output logic signed [2*WIDTH-1:0] dout,
  output logic [WIDTH-1:0]          dout_fx,
  output logic                      dout_ovf,
  output logic [TAG_W-1:0]          dout_tag,
  output logic                      dout_valid,
  input  logic                      dout_ready
);
  localparam int STEPS = (WIDTH + 1) / 2;
  localparam int PW    = 2 * WIDTH;
  localparam int MW    = 2 * STEPS;

  logic adv;
  assign adv       = ~(dout_valid & ~dout_ready);
  assign din_ready = adv;

  logic [STEPS-1:0]             vld_pipe;
  logic [STEPS-1:0][TAG_W-1:0]  tag_pipe;
  logic [STEPS-1:0][WIDTH-1:0]  a_pipe;
  logic [STEPS-1:0][MW:0]       m_pipe;
  logic [STEPS-1:0][PW-1:0]     acc_pipe;

  // Multiplier sign-extended to MW bits with an implicit 0 below the LSB.
  logic [MW:0] m_init;
  assign m_init = {MW'(din2), 1'b0};

  for (genvar j = 0; j < STEPS; j++) begin : g_stage
    logic             sv;
    logic [TAG_W-1:0] st;
    logic [WIDTH-1:0] sa;
    logic [MW:0]      sm;
    logic [PW-1:0]    sacc;

    if (j == 0) begin : g_src0
      assign sv   = din_valid;
      assign st   = din_tag;
      assign sa   = din1;
      assign sm   = m_init;
      assign sacc = '0;
    end else begin : g_srcn
      assign sv   = vld_pipe[j-1];
      assign st   = tag_pipe[j-1];
      assign sa   = a_pipe[j-1];
      assign sm   = m_pipe[j-1];
      assign sacc = acc_pipe[j-1];
    end

    fixed_mul_pipe_stage #(
      .WIDTH(WIDTH), .TAG_W(TAG_W), .MW(MW), .J(j)
    ) u_stage (
      .clk      (clk),
      .nrst     (nrst),
      .adv      (adv),
      .flush    (flush),
      .vld_prev (sv),
      .tag_prev (st),
      .a_prev   (sa),
      .m_prev   (sm),
      .acc_prev (sacc),
      .vld      (vld_pipe[j]),
      .tag      (tag_pipe[j]),
      .a        (a_pipe[j]),
      .m        (m_pipe[j]),
      .acc      (acc_pipe[j])
    );
  end

  // Operands of the last stage have no consumer; synthesis prunes them.
  logic unused_tail;
  assign unused_tail = ^{a_pipe[STEPS-1], m_pipe[STEPS-1]};

  // Rescale: round half toward +inf, then arithmetic shift by FRAC.
  logic [PW-1:0]      p;
  logic signed [PW:0] rnd;
  assign p = acc_pipe[STEPS-1];

  if (FRAC > 0) begin : g_rnd
    localparam logic signed [PW:0] HALF = (PW+1)'(1) <<< (FRAC - 1);
    logic signed [PW:0] sum;
    assign sum = $signed({p[PW-1], p}) + HALF;
    assign rnd = sum >>> FRAC;
  end else begin : g_nornd
    assign rnd = $signed({p[PW-1], p});
  end

  logic [WIDTH-1:0] fx_nxt;
  logic             ovf_nxt;

`ifdef FIXED_MUL_PIPE_SAT_EN
  logic fit;
  assign fit = (&rnd[PW:WIDTH-1]) | (~|rnd[PW:WIDTH-1]);

  always_comb begin
    fx_nxt  = rnd[WIDTH-1:0];
    ovf_nxt = 1'b0;
    if (!fit) begin
      ovf_nxt = 1'b1;
      fx_nxt  = rnd[PW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  logic unused_rnd;
  assign unused_rnd = ^rnd[PW:WIDTH];
  assign fx_nxt     = rnd[WIDTH-1:0];
  assign ovf_nxt    = 1'b0;
`endif

  // Output register: holds everything while stalled; flush clears valid even
  // when stalled.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_fx    <= '0;
      dout_ovf   <= 1'b0;
      dout_tag   <= '0;
    end else begin
      if (flush)    dout_valid <= 1'b0;
      else if (adv) dout_valid <= vld_pipe[STEPS-1];
      if (adv) begin
        dout     <= p;
        dout_fx  <= fx_nxt;
        dout_ovf <= ovf_nxt;
        dout_tag <= tag_pipe[STEPS-1];
      end
    end
  end
endmodule

// File: doc/fixed_mul_pipe.md
FIXED_MUL_PIPE -- requirements
Module: fixed_mul_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 26, operand width in bits; any integer 4..32, odd values allowed.
REQ-002 SHALL provide parameter FRAC, default 13, fractional bits of the fixed-point format; 0..WIDTH-1.
REQ-003 SHALL provide parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 nrst  in  1  reset, asynchronous assertion, active-low.
REQ-006 din1  in  WIDTH  signed multiplicand, two's complement.
REQ-007 din2  in  WIDTH  signed multiplier, two's complement.
REQ-008 din_tag  in  TAG_W  sideband tag, returned unchanged with the result.
REQ-009 din_valid  in  1  input operands valid.
REQ-010 din_ready  out  1  block accepts an operand pair this cycle.
REQ-011 flush  in  1  synchronous drop of all in-flight operations.
REQ-012 dout  out  2*WIDTH  full signed product din1*din2.
REQ-013 dout_fx  out  WIDTH  product rescaled to the input Q format (see REQ-021).
REQ-014 dout_ovf  out  1  dout_fx did not fit in WIDTH bits.
REQ-015 dout_tag  out  TAG_W  tag of the operation on dout.
REQ-016 dout_valid  out  1  result valid.
REQ-017 dout_ready  in  1  downstream accepts the result.

Function
REQ-018 Multiplier SHALL be radix-4 Booth; STEPS = ceil(WIDTH/2); din2 sign-extended to 2*STEPS bits; one partial product accumulated per pipeline stage.
REQ-019 Latency SHALL be L = STEPS+1 cycles from accepted input (din_valid & din_ready) to dout_valid with no stall; 26-bit default gives L=14.
REQ-020 Throughput SHALL be one operation per cycle while unstalled; results SHALL emerge in acceptance order with their tags.
REQ-021 dout_fx SHALL equal (P + 2^(FRAC-1)) >>> FRAC for FRAC>0 and P for FRAC=0, where P is the full product; rounding is half toward +infinity.
REQ-022 Stall: when dout_valid=1 and dout_ready=0, the whole pipeline SHALL hold every register; din_ready = ~(dout_valid & ~dout_ready).
REQ-023 dout, dout_fx, dout_ovf, dout_tag SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-024 Bubbles (din_valid=0) SHALL propagate as invalid stages; they do not stall the pipeline.
REQ-025 flush=1 SHALL clear every stage valid and dout_valid on the next edge; any input presented with flush is discarded; flush has priority over stall.
REQ-026 Most-negative × most-negative SHALL produce the exact 2*WIDTH product 2^(2*WIDTH-2) on dout.
REQ-027 Data registers SHALL load only when their stage advances; only valid bits need reset.

Reset
REQ-028 nrst=0 SHALL asynchronously clear all stage valids and dout_valid to 0.
REQ-029 While nrst=0 and on the first edge after release, din_ready SHALL be 1; dout, dout_fx, dout_tag SHALL reset to 0 and dout_ovf to 0.
REQ-030 Reset mid-operation SHALL discard all in-flight operations; none appear after release.

Configuration
REQ-031 Macro FIXED_MUL_PIPE_SAT_EN defined: dout_fx SHALL saturate to 2^(WIDTH-1)-1 or -2^(WIDTH-1) when the rounded value exceeds WIDTH signed bits, with dout_ovf=1.
REQ-032 Macro undefined: dout_fx SHALL be the low WIDTH bits of the rounded value (wrap); dout_ovf SHALL be constant 0; no saturation logic instantiated.

Verification (WIDTH=26, FRAC=13, TAG_W=4)
REQ-033 din1=3, din2=-5, tag=0xA, dout_ready=1 -> 14 cycles later dout=-15 (0xFFFFFFFFFFFF1), dout_tag=0xA, one-cycle dout_valid pulse.
REQ-034 din1=12288 (1.5), din2=-16384 (-2.0) -> dout=-201326592, dout_fx=-24576 (0x3FFA000), dout_ovf=0.
REQ-035 din1=din2=-2^25 -> dout=2^50; with FIXED_MUL_PIPE_SAT_EN dout_fx=0x1FFFFFF, dout_ovf=1; without it dout_fx=0, dout_ovf=0.
REQ-036 200 random back-to-back operands, dout_ready random 50% -> every result matches reference model, tags in order, no loss or duplication, outputs stable while stalled.
REQ-037 5 operations in flight, flush pulsed 1 cycle -> no dout_valid for those 5; next operation returns correct result after 14 cycles.
REQ-038 nrst pulsed low with pipeline full and dout stalled -> dout_valid=0 immediately, din_ready=1 after release, no stale results emitted.
